// File: rtl/sbox_share_ctrl_if.sv
// Bundles the requester handshakes, the shared S-box lane operand/result and the busy flag.
// slave is the arbiter side; master is the requester/lane side.
interface sbox_share_ctrl_if;
   logic         ks_valid;
   logic [31:0]  ks_word;
   logic         ks_ready;
   logic         ks_done;
   logic [31:0]  ks_res;
   logic         rd_valid;
   logic [127:0] rd_data;
   logic         rd_ready;
   logic         rd_done;
   logic [127:0] rd_sb;
   logic [31:0]  sbox_in;
   logic [31:0]  sbox_out;
   logic         busy;

   modport slave (
      input  ks_valid, ks_word, rd_valid, rd_data, sbox_out,
      output ks_ready, ks_done, ks_res, rd_ready, rd_done, rd_sb, sbox_in, busy
   );

   modport master (
      output ks_valid, ks_word, rd_valid, rd_data, sbox_out,
      input  ks_ready, ks_done, ks_res, rd_ready, rd_done, rd_sb, sbox_in, busy
   );
endinterface

// File: rtl/sbox_share_ctrl.sv
// Arbitrates one combinational 32-bit SubWord lane between the key scheduler (1 beat)
// and the round datapath (4 beats, MSW first).
module sbox_share_ctrl #(
   parameter int unsigned PRIO_MODE = 0,
   parameter int unsigned IDLE_ZERO = 1
) (
   input logic              clk,
   input logic              rst_n,
   sbox_share_ctrl_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StKs, StRd} state_e;

   state_e       state_q, state_d;
   logic [1:0]   beat_q, beat_d;
   logic         lg_ks_q, lg_ks_d;
   logic [31:0]  ks_word_q, ks_word_d;
   logic [127:0] rd_data_q, rd_data_d;
   logic [95:0]  acc_q, acc_d;
   logic [31:0]  ks_res_q, ks_res_d;
   logic [127:0] rd_sb_q, rd_sb_d;
   logic         ks_done_q, ks_done_d;
   logic         rd_done_q, rd_done_d;
   logic [31:0]  hold_q, hold_d;

   logic         ks_wins;
   logic         ks_rdy;
   logic         rd_rdy;
   logic [31:0]  rd_word;
   logic [31:0]  operand;

   always_comb begin
      // Each ready looks only at the other side's valid, so a requester never waits on itself.
      ks_wins = (PRIO_MODE != 0) || !lg_ks_q;
      ks_rdy  = (state_q == StIdle) && (!bus.rd_valid || ks_wins);
      rd_rdy  = (state_q == StIdle) && (!bus.ks_valid || !ks_wins);

      unique case (beat_q)
         2'd0:    rd_word = rd_data_q[127:96];
         2'd1:    rd_word = rd_data_q[95:64];
         2'd2:    rd_word = rd_data_q[63:32];
         default: rd_word = rd_data_q[31:0];
      endcase

      operand   = (IDLE_ZERO != 0) ? 32'h0 : hold_q;
      state_d   = state_q;
      beat_d    = beat_q;
      lg_ks_d   = lg_ks_q;
      ks_word_d = ks_word_q;
      rd_data_d = rd_data_q;
      acc_d     = acc_q;
      ks_res_d  = ks_res_q;
      rd_sb_d   = rd_sb_q;
      ks_done_d = 1'b0;
      rd_done_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.ks_valid && ks_rdy) begin
               ks_word_d = bus.ks_word;
               lg_ks_d   = 1'b1;
               state_d   = StKs;
            end else if (bus.rd_valid && rd_rdy) begin
               rd_data_d = bus.rd_data;
               beat_d    = 2'd0;
               lg_ks_d   = 1'b0;
               state_d   = StRd;
            end
         end
         StKs: begin
            operand   = ks_word_q;
            ks_res_d  = bus.sbox_out;
            ks_done_d = 1'b1;
            state_d   = StIdle;
         end
         StRd: begin
            operand = rd_word;
            beat_d  = beat_q + 2'd1;
            unique case (beat_q)
               2'd0: acc_d[95:64] = bus.sbox_out;
               2'd1: acc_d[63:32] = bus.sbox_out;
               2'd2: acc_d[31:0]  = bus.sbox_out;
               default: begin
                  // Publish all four beats at once so rd_sb never exposes a partial state.
                  rd_sb_d   = {acc_q, bus.sbox_out};
                  rd_done_d = 1'b1;
                  state_d   = StIdle;
               end
            endcase
         end
         default: state_d = StIdle;
      endcase

      hold_d = (state_q != StIdle) ? operand : hold_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         beat_q    <= 2'd0;
         lg_ks_q   <= 1'b0;
         ks_word_q <= '0;
         rd_data_q <= '0;
         acc_q     <= '0;
         ks_res_q  <= '0;
         rd_sb_q   <= '0;
         ks_done_q <= 1'b0;
         rd_done_q <= 1'b0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         lg_ks_q   <= lg_ks_d;
         ks_word_q <= ks_word_d;
         rd_data_q <= rd_data_d;
         acc_q     <= acc_d;
         ks_res_q  <= ks_res_d;
         rd_sb_q   <= rd_sb_d;
         ks_done_q <= ks_done_d;
         rd_done_q <= rd_done_d;
         hold_q    <= hold_d;
      end
   end

   assign bus.ks_ready = ks_rdy;
   assign bus.rd_ready = rd_rdy;
   assign bus.ks_done  = ks_done_q;
   assign bus.rd_done  = rd_done_q;
   assign bus.ks_res   = ks_res_q;
   assign bus.rd_sb    = rd_sb_q;
   assign bus.sbox_in  = operand;
   assign bus.busy     = (state_q != StIdle);

endmodule
